// File: rtl/uart_pulse_cmd_parser.sv
// Collects 9-byte pulse-command frames from uart_rx, validates and clamps the fields, holds them
// for functionGenerate and answers each frame with a one-byte status for uart_tx.
module uart_pulse_cmd_parser #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned UART_BPS      = 9600,
    parameter int unsigned TIMEOUT_BYTES = 3,
    parameter int unsigned MIN_VAL       = 4,
    parameter logic [15:0] DEF_W1        = 16'd1500,
    parameter logic [15:0] DEF_W2        = 16'd500,
    parameter logic [15:0] DEF_GAP       = 16'd500,
    parameter logic [1:0]  DEF_SEL       = 2'b01
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  po_data,
    input  logic        po_flag,
    output logic [1:0]  pulse_select,
    output logic [15:0] pulse_width1,
    output logic [15:0] pulse_width2,
    output logic [15:0] pulse_gap,
    output logic        cmd_valid,
    output logic [7:0]  ack_data,
    output logic        ack_flag,
    output logic        busy
);

    localparam int unsigned TIMEOUT_CYC = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
    localparam int unsigned TMO_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0] MIN_V = 16'(MIN_VAL);

    localparam logic [7:0] HDR      = 8'h07;
    localparam logic [7:0] CODE_OK  = 8'hA5;
    localparam logic [7:0] CODE_BAD = 8'hE0;
    localparam logic [7:0] CODE_TMO = 8'hE1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       b1_q, b1_d, b2_q, b2_d;
    logic [15:0]      fw1_q, fw1_d, fw2_q, fw2_d, fgap_q, fgap_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      w1_q, w1_d, w2_q, w2_d, gap_q, gap_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             ack_flag_q, ack_flag_d;
    logic [7:0]       ack_data_q, ack_data_d;
    logic             busy_q, busy_d;

    function automatic logic [15:0] clamp(input logic [15:0] f);
        return (f < MIN_V) ? MIN_V : f;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        fw1_d       = fw1_q;
        fw2_d       = fw2_q;
        fgap_d      = fgap_q;
        sel_d       = sel_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        gap_d       = gap_q;
        cmd_valid_d = 1'b0;
        ack_flag_d  = 1'b0;
        ack_data_d  = ack_data_q;
        case (state_q)
            ST_IDLE: begin
                if (po_flag && po_data == HDR) begin
                    idx_d   = 4'd1;
                    tmo_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (po_flag) begin
                    case (idx_q)
                        4'd1:    b1_d         = po_data;
                        4'd2:    b2_d         = po_data;
                        4'd3:    fw1_d[15:8]  = po_data;
                        4'd4:    fw1_d[7:0]   = po_data;
                        4'd5:    fw2_d[15:8]  = po_data;
                        4'd6:    fw2_d[7:0]   = po_data;
                        4'd7:    fgap_d[15:8] = po_data;
                        4'd8:    fgap_d[7:0]  = po_data;
                        default: ;
                    endcase
                    idx_d = idx_q + 4'd1;
                    tmo_d = '0;
                    if (idx_q == 4'd8) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d      = '0;
                    ack_flag_d = 1'b1;
                    ack_data_d = CODE_TMO;
                    state_d    = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                ack_flag_d = 1'b1;
                state_d    = ST_RESP;
                if (b1_q > 8'd1 || b2_q > 8'd1) begin
                    ack_data_d = CODE_BAD;
                end else begin
                    ack_data_d  = CODE_OK;
                    cmd_valid_d = 1'b1;
                    sel_d       = {b2_q[0], b1_q[0]};
                    w1_d        = clamp(fw1_q);
                    w2_d        = clamp(fw2_q);
                    gap_d       = clamp(fgap_q);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            tmo_q       <= '0;
            b1_q        <= 8'h00;
            b2_q        <= 8'h00;
            fw1_q       <= 16'h0000;
            fw2_q       <= 16'h0000;
            fgap_q      <= 16'h0000;
            sel_q       <= DEF_SEL;
            w1_q        <= DEF_W1;
            w2_q        <= DEF_W2;
            gap_q       <= DEF_GAP;
            cmd_valid_q <= 1'b0;
            ack_flag_q  <= 1'b0;
            ack_data_q  <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            fw1_q       <= fw1_d;
            fw2_q       <= fw2_d;
            fgap_q      <= fgap_d;
            sel_q       <= sel_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            gap_q       <= gap_d;
            cmd_valid_q <= cmd_valid_d;
            ack_flag_q  <= ack_flag_d;
            ack_data_q  <= ack_data_d;
            busy_q      <= busy_d;
        end
    end

    assign pulse_select = sel_q;
    assign pulse_width1 = w1_q;
    assign pulse_width2 = w2_q;
    assign pulse_gap    = gap_q;
    assign cmd_valid    = cmd_valid_q;
    assign ack_flag     = ack_flag_q;
    assign ack_data     = ack_data_q;
    assign busy         = busy_q;

endmodule
